// File: rtl/sram_prog_loader.sv
// Boot-time loader: reads a contiguous program image from async SRAM and
// streams it, word by word with its index, to the instruction memory.
module sram_prog_loader #(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 16,
  parameter int                IDX_W       = 10,
  parameter int                PROG_WORDS  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2,
  parameter bit                STOP_ON_END = 1'b1,
  parameter logic [DATA_W-1:0] END_WORD    = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [DATA_W-1:0] word_data,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    word_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    HOLD   = 2'd2,
    DONE_S = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PROG_WORDS - 1);
  localparam logic [3:0]       WAIT_LAST = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       sel_n;
  logic       last_word;

  // All SRAM strobes move together; the device is only ever read.
  assign sram_ce_n = sel_n;
  assign sram_oe_n = sel_n;
  assign sram_lb_n = sel_n;
  assign sram_ub_n = sel_n;
  assign sram_we_n = 1'b1;
  assign state_dbg = state;

  assign last_word = (word_idx == LAST_IDX) ||
                     (STOP_ON_END && (word_data == END_WORD));

  // Handshake: word_data/word_idx are held while word_valid=1 and a word moves
  // only on a cycle with word_valid & word_ready; ready alone does nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      sel_n      <= 1'b1;
      sram_addr  <= BASE_ADDR;
      word_data  <= '0;
      word_idx   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE_S: begin
          if (start) begin
            state      <= READ;
            wait_cnt   <= '0;
            sel_n      <= 1'b0;
            sram_addr  <= BASE_ADDR;
            word_idx   <= '0;
            word_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        READ: begin
          if (wait_cnt == WAIT_LAST) begin
            state      <= HOLD;
            word_data  <= sram_dq_in;
            word_valid <= 1'b1;
            sel_n      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            word_count <= word_count + (IDX_W+1)'(1);
            if (last_word) begin
              state <= DONE_S;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= READ;
              wait_cnt  <= '0;
              sel_n     <= 1'b0;
              word_idx  <= word_idx + IDX_W'(1);
              sram_addr <= sram_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_prog_loader.sv
// Directed bench: instance a (4 words, 2 wait states, stop on end marker) and
// instance b (8 words, no wait states, base 0x10, no early stop).
module tb_sram_prog_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:63];
  int          rd_cnt_a [0:63];

  logic        start_a = 1'b0, start_b = 1'b0;
  logic        ready_a = 1'b0, ready_b = 1'b0;
  logic [15:0] dq_a, dq_b, data_a, data_b;
  logic [19:0] addr_a, addr_b;
  logic        ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a;
  logic        ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b;
  logic [9:0]  idx_a, idx_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [10:0] count_a, count_b;
  logic [1:0]  st_a, st_b;

  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  sram_prog_loader #(.PROG_WORDS(4), .WAIT_CYCLES(2), .BASE_ADDR(20'h0),
                     .STOP_ON_END(1'b1), .END_WORD(16'hFFFF)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .sram_dq_in(dq_a),
    .sram_addr(addr_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a),
    .sram_we_n(we_n_a), .sram_lb_n(lb_n_a), .sram_ub_n(ub_n_a),
    .word_data(data_a), .word_idx(idx_a), .word_valid(valid_a),
    .word_ready(ready_a), .busy(busy_a), .done(done_a),
    .word_count(count_a), .state_dbg(st_a));

  sram_prog_loader #(.PROG_WORDS(8), .WAIT_CYCLES(0), .BASE_ADDR(20'h10),
                     .STOP_ON_END(1'b0), .END_WORD(16'hFFFF)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .sram_dq_in(dq_b),
    .sram_addr(addr_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
    .sram_we_n(we_n_b), .sram_lb_n(lb_n_b), .sram_ub_n(ub_n_b),
    .word_data(data_b), .word_idx(idx_b), .word_valid(valid_b),
    .word_ready(ready_b), .busy(busy_b), .done(done_b),
    .word_count(count_b), .state_dbg(st_b));

  // Async SRAM model: drives data only while selected and output-enabled.
  assign dq_a = (!ce_n_a && !oe_n_a) ? mem[addr_a[5:0]] : 16'h0BAD;
  assign dq_b = (!ce_n_b && !oe_n_b) ? mem[addr_b[5:0]] : 16'h0BAD;

  always @(posedge clk)
    if (!ce_n_a && !oe_n_a) rd_cnt_a[addr_a[5:0]] <= rd_cnt_a[addr_a[5:0]] + 1;

  always @(posedge clk) begin
    checks <= checks + 1;
    if (we_n_a !== 1'b1 || we_n_b !== 1'b1) begin
      errors <= errors + 1;
      $display("FAIL we_n_const a=%b b=%b required 1", we_n_a, we_n_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_valid_a(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid_a && cyc < budget);
    if (!valid_a) begin
      errors++;
      $display("FAIL valid_timeout_a waited %0d cycles required valid=1", cyc);
    end
  endtask

  task automatic wait_done_a(input int budget);
    int cyc = 0;
    while (!done_a && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done_a) begin
      errors++;
      $display("FAIL done_timeout_a waited %0d cycles required done=1", cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a} !== 5'b11111) begin errors++;
      $display("FAIL reset_strobes got %b required 11111", {ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a}); end
    checks++; if (addr_a !== 20'h0) begin errors++; $display("FAIL reset_addr_a got %h required 0", addr_a); end
    checks++; if (addr_b !== 20'h10) begin errors++; $display("FAIL reset_addr_b got %h required 10", addr_b); end
    checks++; if (data_a !== 16'h0 || idx_a !== 10'd0) begin errors++;
      $display("FAIL reset_data_idx got %h/%0d required 0/0", data_a, idx_a); end
    checks++; if ({valid_a, busy_a, done_a} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b required 000", {valid_a, busy_a, done_a}); end
    checks++; if (count_a !== 11'd0 || st_a !== 2'd0) begin errors++;
      $display("FAIL reset_count_state got %0d/%0d required 0/0", count_a, st_a); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    int cyc;
    exp_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ready_a = 1'b1;
    pulse_start_a();
    for (int k = 0; k < 4; k++) begin
      wait_valid_a(20, cyc);
      exp_w = exp_q.pop_front();
      checks++; if (cyc + 1 != 4) begin errors++; $display("FAIL stream_period k=%0d got %0d required 4", k, cyc + 1); end
      checks++; if (idx_a !== 10'(k)) begin errors++; $display("FAIL stream_idx got %0d required %0d", idx_a, k); end
      checks++; if (data_a !== exp_w) begin errors++; $display("FAIL stream_data got %h required %h", data_a, exp_w); end
      checks++; if (busy_a !== 1'b1 || oe_n_a !== 1'b1) begin errors++;
        $display("FAIL stream_hold busy/oe_n got %b%b required 11", busy_a, oe_n_a); end
      @(negedge clk);
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL stream_valid_drop got %b required 0", valid_a); end
      checks++; if (count_a !== 11'(k + 1)) begin errors++; $display("FAIL stream_count got %0d required %0d", count_a, k + 1); end
    end
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin errors++;
      $display("FAIL stream_done done/busy got %b%b required 10", done_a, busy_a); end
  endtask

  task automatic test_backpressure();
    int cyc;
    ready_a = 1'b0;
    pulse_start_a();
    wait_valid_a(20, cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (valid_a !== 1'b1 || data_a !== 16'h1111) begin errors++;
        $display("FAIL bp_hold valid/data got %b/%h required 1/1111", valid_a, data_a); end
      checks++; if (oe_n_a !== 1'b1 || addr_a !== 20'h0 || idx_a !== 10'd0) begin errors++;
        $display("FAIL bp_bus oe_n/addr/idx got %b/%h/%0d required 1/0/0", oe_n_a, addr_a, idx_a); end
    end
    ready_a = 1'b1;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0 || count_a !== 11'd1) begin errors++;
      $display("FAIL bp_advance valid/count got %b/%0d required 0/1", valid_a, count_a); end
    checks++; if (addr_a !== 20'h1 || idx_a !== 10'd1 || oe_n_a !== 1'b0) begin errors++;
      $display("FAIL bp_next addr/idx/oe_n got %h/%0d/%b required 1/1/0", addr_a, idx_a, oe_n_a); end
    wait_done_a(40);
    checks++; if (count_a !== 11'd4) begin errors++; $display("FAIL bp_count got %0d required 4", count_a); end
  endtask

  task automatic test_restart_from_done();
    int cyc;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rs_pre_done got %b required 1", done_a); end
    pulse_start_a();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b1 || st_a !== 2'd1) begin errors++;
      $display("FAIL rs_flags done/busy/state got %b/%b/%0d required 0/1/1", done_a, busy_a, st_a); end
    checks++; if (addr_a !== 20'h0 || idx_a !== 10'd0 || count_a !== 11'd0) begin errors++;
      $display("FAIL rs_regs addr/idx/count got %h/%0d/%0d required 0/0/0", addr_a, idx_a, count_a); end
    exp_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) begin
      wait_valid_a(20, cyc);
      exp_w = exp_q.pop_front();
      checks++; if (idx_a !== 10'(k) || data_a !== exp_w) begin errors++;
        $display("FAIL rs_word idx/data got %0d/%h required %0d/%h", idx_a, data_a, k, exp_w); end
      @(negedge clk);
    end
    checks++; if (done_a !== 1'b1 || count_a !== 11'd4) begin errors++;
      $display("FAIL rs_end done/count got %b/%0d required 1/4", done_a, count_a); end
  endtask

  task automatic test_stop_on_end();
    int cyc, rd2, rd3;
    mem[2] = 16'hFFFF;
    rd2 = rd_cnt_a[2];
    rd3 = rd_cnt_a[3];
    exp_q = {16'h1111, 16'h2222, 16'hFFFF};
    pulse_start_a();
    for (int k = 0; k < 3; k++) begin
      wait_valid_a(20, cyc);
      exp_w = exp_q.pop_front();
      checks++; if (idx_a !== 10'(k) || data_a !== exp_w) begin errors++;
        $display("FAIL soe_word idx/data got %0d/%h required %0d/%h", idx_a, data_a, k, exp_w); end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 11'd3) begin errors++;
      $display("FAIL soe_end done/busy/count got %b/%b/%0d required 1/0/3", done_a, busy_a, count_a); end
    checks++; if (rd_cnt_a[3] != rd3 || addr_a !== 20'h2) begin errors++;
      $display("FAIL soe_no_read3 reads=%0d addr=%h required 0/2", rd_cnt_a[3] - rd3, addr_a); end
    checks++; if (rd_cnt_a[2] == rd2) begin errors++; $display("FAIL soe_read2 reads=0 required >0"); end
    mem[2] = 16'h3333;
  endtask

  task automatic test_ignore_start_and_abort();
    int cyc;
    ready_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++; if (st_b !== 2'd1 || addr_b !== 20'h10 || oe_n_b !== 1'b0) begin errors++;
      $display("FAIL b_first_read state/addr/oe_n got %0d/%h/%b required 1/10/0", st_b, addr_b, oe_n_b); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++; if (valid_b !== 1'b1 || idx_b !== 10'(k) || data_b !== 16'hB000 + 16'(k)) begin errors++;
        $display("FAIL b_word valid/idx/data got %b/%0d/%h required 1/%0d/%h", valid_b, idx_b, data_b, k, 16'hB000 + 16'(k)); end
      start_b = (k == 1);
      @(negedge clk);
      start_b = (k == 3);
      checks++; if (valid_b !== 1'b0 || count_b !== 11'(k + 1) || st_b !== 2'd1) begin errors++;
        $display("FAIL b_after_hs valid/count/state got %b/%0d/%0d required 0/%0d/1", valid_b, count_b, st_b, k + 1); end
      if (k < 4) @(negedge clk);
      start_b = 1'b0;
    end
    checks++; if (idx_b !== 10'd5 || addr_b !== 20'h15 || ce_n_b !== 1'b0) begin errors++;
      $display("FAIL b_read5 idx/addr/ce_n got %0d/%h/%b required 5/15/0", idx_b, addr_b, ce_n_b); end
    reset_n = 1'b0;
    #1;
    checks++; if (addr_b !== 20'h10 || {ce_n_b, oe_n_b, lb_n_b, ub_n_b} !== 4'b1111) begin errors++;
      $display("FAIL abort_bus addr/strobes got %h/%b required 10/1111", addr_b, {ce_n_b, oe_n_b, lb_n_b, ub_n_b}); end
    checks++; if ({valid_b, busy_b, done_b} !== 3'b000 || count_b !== 11'd0 || idx_b !== 10'd0 || data_b !== 16'h0) begin errors++;
      $display("FAIL abort_regs flags/count/idx/data got %b/%0d/%0d/%h required 000/0/0/0", {valid_b, busy_b, done_b}, count_b, idx_b, data_b); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++; if (addr_b !== 20'h10 || idx_b !== 10'd0 || st_b !== 2'd1) begin errors++;
      $display("FAIL b_restart addr/idx/state got %h/%0d/%0d required 10/0/1", addr_b, idx_b, st_b); end
    @(negedge clk);
    checks++; if (valid_b !== 1'b1 || data_b !== 16'hB000) begin errors++;
      $display("FAIL b_restart_word valid/data got %b/%h required 1/B000", valid_b, data_b); end
    cyc = 0;
    while (!done_b && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (done_b !== 1'b1 || count_b !== 11'd8 || idx_b !== 10'd7 || data_b !== 16'hB007) begin errors++;
      $display("FAIL b_full done/count/idx/data got %b/%0d/%0d/%h required 1/8/7/B007", done_b, count_b, idx_b, data_b); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'h5A00 + 16'(i);
      rd_cnt_a[i] = 0;
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    for (int i = 0; i < 8; i++) mem[16 + i] = 16'hB000 + 16'(i);

    test_reset();
    test_stream();
    test_backpressure();
    test_restart_from_done();
    test_stop_on_end();
    test_ignore_start_and_abort();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
